muldiv_ctl: RTL and testbench

- Multi-cycle multiply/divide sequencer with the architectural HI/LO registers.
- Sits beside the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decode/issue path and runs an iterative shift-add or restoring-divide datapath.
- Asserts stall toward decode while an MFHI/MFLO or a new mul/div op must wait for the unit.

---
 rtl/muldiv_ctl_pkg.sv | 47 ++++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_ctl.sv | 174 +++++++++++++++++
 tb/tb_muldiv_ctl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctl_pkg.sv
// Shared types and helpers for the multiply/divide sequencer.
// Operand classification lives here so decode can reuse it.
package muldiv_ctl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_ITER,
    MD_FIXUP
  } muldiv_state_t;

  function automatic logic op_is_md(
    input muldiv_op_t o
  );
    return o inside {MD_MULT, MD_MULTU,
                     MD_DIV, MD_DIVU};
  endfunction

  function automatic logic op_is_signed(
    input muldiv_op_t o
  );
    return o inside {MD_MULT, MD_DIV};
  endfunction

  function automatic logic op_is_div(
    input muldiv_op_t o
  );
    return o inside {MD_DIV, MD_DIVU};
  endfunction

  // 0x80000000 maps to itself, read as unsigned
  function automatic logic [31:0] mag32(
    input logic [31:0] x,
    input logic        sg
  );
    return (sg && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; chained to unroll several steps per clock.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] d,
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] sum;
  logic [32:0] sh;
  logic [33:0] diff;

  always_comb begin
    sum   = rem_i + {1'b0, (quo_i[0] ? d : 32'h0)};
    sh    = {rem_i[31:0], quo_i[31]};
    diff  = {1'b0, sh} - {2'b00, d};
    rem_o = {1'b0, sum[32:1]};
    quo_o = {sum[0], quo_i[31:1]};
    if (is_div) begin
      // borrow clear means the trial subtract fits
      if (!diff[33]) begin
        rem_o = diff[32:0];
        quo_o = {quo_i[30:0], 1'b1};
      end else begin
        rem_o = sh;
        quo_o = {quo_i[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctl.sv
// Iterative multiply/divide unit with HI/LO and decode stall.
// Magnitudes iterate unsigned; signs are applied in FIXUP.
module muldiv_ctl
  import muldiv_ctl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mfhilo_req,
  input  logic        mfhilo_sel,
  output logic [31:0] mfhilo_data,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  muldiv_state_t state, state_n;

  logic          div_q;
  logic          sa;
  logic          sb;
  logic [31:0]   a_raw;
  logic [31:0]   dv;
  logic [31:0]   quo;
  logic [32:0]   rem;
  logic [CW-1:0] cnt;

  logic          st_sg;
  logic          st_div;
  logic [32:0]   rem_nx;
  logic [31:0]   quo_nx;

  logic          neg;
  logic          div0;
  logic [63:0]   prod;
  logic [63:0]   prod_f;
  logic [31:0]   q_f;
  logic [31:0]   r_f;

  assign busy        = (state != MD_IDLE);
  assign stall       = busy && (start || mfhilo_req);
  assign mfhilo_data = mfhilo_sel ? hi : lo;

  assign st_sg  = op_is_signed(op);
  assign st_div = op_is_div(op);

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [32:0] r_in;
    logic [32:0] r_out;
    logic [31:0] q_in;
    logic [31:0] q_out;
    if (i == 0) begin : g_first
      assign r_in = rem;
      assign q_in = quo;
    end else begin : g_next
      assign r_in = g_step[i-1].r_out;
      assign q_in = g_step[i-1].q_out;
    end
    muldiv_step u_step (
      .is_div (div_q),
      .d      (dv),
      .rem_i  (r_in),
      .quo_i  (q_in),
      .rem_o  (r_out),
      .quo_o  (q_out)
    );
  end

  assign rem_nx = g_step[BITS_PER_CYCLE-1].r_out;
  assign quo_nx = g_step[BITS_PER_CYCLE-1].q_out;

  // Result sign correction
  assign neg    = sa ^ sb;
  assign div0   = (dv == 32'h0);
  assign prod   = {rem[31:0], quo};
  assign prod_f = neg ? -prod : prod;
  assign q_f    = neg ? -quo : quo;
  assign r_f    = sa ? -rem[31:0] : rem[31:0];

  always_ff @(posedge clock) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MD_IDLE: begin
        if (start && op_is_md(op))
          state_n = MD_ITER;
      end
      MD_ITER: begin
        if (cnt == '0)
          state_n = MD_FIXUP;
      end
      MD_FIXUP: state_n = MD_IDLE;
      default:  state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      div_q <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      a_raw <= '0;
      dv    <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            if (op == MD_MTHI) begin
              hi <= A;
            end else if (op == MD_MTLO) begin
              lo <= A;
            end else if (op_is_md(op)) begin
              div_q <= st_div;
              sa    <= st_sg & A[31];
              sb    <= st_sg & B[31];
              a_raw <= A;
              rem   <= '0;
              cnt   <= CNT_INIT;
              if (st_div) begin
                quo <= mag32(A, st_sg);
                dv  <= mag32(B, st_sg);
              end else begin
                quo <= mag32(B, st_sg);
                dv  <= mag32(A, st_sg);
              end
            end
          end
        end
        MD_ITER: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
        end
        MD_FIXUP: begin
          done <= 1'b1;
          if (!div_q) begin
            hi <= prod_f[63:32];
            lo <= prod_f[31:0];
          end else if (div0) begin
            hi <= a_raw;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= r_f;
            lo <= q_f;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctl.sv
// Directed bench: three instances at 1, 2 and 4 steps per clock.
// Shared stimulus; per-instance timing derived from N = 32 >> g.
module tb_muldiv_ctl;
  import muldiv_ctl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mfhilo_req = 1'b0;
  logic        mfhilo_sel = 1'b0;
  muldiv_op_t  op = MD_MULT;
  logic [31:0] A = '0;
  logic [31:0] B = '0;

  logic        busy  [3];
  logic        stall [3];
  logic        done  [3];
  logic [31:0] hi    [3];
  logic [31:0] lo    [3];
  logic [31:0] mfd   [3];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    muldiv_ctl #(.BITS_PER_CYCLE(1 << g)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .A           (A),
      .B           (B),
      .mfhilo_req  (mfhilo_req),
      .mfhilo_sel  (mfhilo_sel),
      .mfhilo_data (mfd[g]),
      .busy        (busy[g]),
      .stall       (stall[g]),
      .done        (done[g]),
      .hi          (hi[g]),
      .lo          (lo[g])
    );
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: hold MFHI request;
  // 2: hold an MTHI start while busy
  task automatic run_op(
    input string       tag,
    input muldiv_op_t  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] eh,
    input logic [31:0] el,
    input int          mode
  );
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    mfhilo_req = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clock);
      #1;
      case (mode)
        1: begin
          start      = 1'b0;
          mfhilo_req = 1'b1;
          mfhilo_sel = 1'b1;
        end
        2: begin
          start = 1'b1;
          op    = MD_MTHI;
          A     = 32'hCAFE_F00D;
        end
        default: start = 1'b0;
      endcase
      #1;
      for (int g = 0; g < 3; g++) begin
        int n;
        string t;
        n = 32 >> g;
        t = $sformatf("%s.b%0d.c%0d", tag, 1 << g, c);
        chk({t, ".busy"}, 32'(busy[g]),
            32'(c <= n + 1));
        chk({t, ".done"}, 32'(done[g]),
            32'(c == n + 2));
        chk({t, ".stall"}, 32'(stall[g]),
            32'((mode != 0) && (c <= n + 1)));
        if (c == n + 2) begin
          chk({t, ".hi"}, hi[g], eh);
          chk({t, ".lo"}, lo[g], el);
          if (mode == 1)
            chk({t, ".mfhi"}, mfd[g], eh);
        end
        if (c == n + 3 && mode == 2) begin
          chk({t, ".mthi"}, hi[g], 32'hCAFE_F00D);
          chk({t, ".lokeep"}, lo[g], el);
        end
      end
    end
    start      = 1'b0;
    mfhilo_req = 1'b0;
    op         = MD_MULT;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst.busy", 32'(busy[g]), 32'h0);
      chk("rst.done", 32'(done[g]), 32'h0);
      chk("rst.stall", 32'(stall[g]), 32'h0);
      chk("rst.hi", hi[g], 32'h0);
      chk("rst.lo", lo[g], 32'h0);
    end

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE,
           32'h0000_0001, 0);
    run_op("mult_n3x7", MD_MULT, -32'sd3, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
    run_op("div_n7d2", MD_DIV, -32'sd7, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7dn2", MD_DIV, 32'd7, -32'sd2,
           32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("div_n8d3", MD_DIV, -32'sd8, 32'd3,
           32'hFFFF_FFFE, 32'hFFFF_FFFE, 0);
    run_op("divu_100d7", MD_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 2);
    run_op("div_5d0", MD_DIV, 32'd5, 32'd0,
           32'd5, 32'hFFFF_FFFF, 0);
    run_op("divu_d0", MD_DIVU, 32'h8000_0000,
           32'd0, 32'h8000_0000,
           32'hFFFF_FFFF, 0);
    run_op("mult_min", MD_MULT, 32'h8000_0000,
           32'h8000_0000, 32'h4000_0000,
           32'h0000_0000, 0);

    start = 1'b1;
    op    = MD_MTLO;
    A     = 32'h1234_5678;
    @(posedge clock);
    #1;
    start = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("mtlo.lo", lo[g], 32'h1234_5678);
      chk("mtlo.hi", hi[g], 32'h4000_0000);
      chk("mtlo.busy", 32'(busy[g]), 32'h0);
      chk("mtlo.done", 32'(done[g]), 32'h0);
    end

    start = 1'b1;
    op    = MD_DIV;
    A     = 32'd100;
    B     = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (c == 5) reset = 1'b1;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("midrst.busy", 32'(busy[g]), 32'h0);
      chk("midrst.hi", hi[g], 32'h0);
      chk("midrst.lo", lo[g], 32'h0);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int g = 0; g < 3; g++)
        seen = seen | done[g];
      @(posedge clock);
      #1;
    end
    chk("midrst.nodone", 32'(seen), 32'h0);

    run_op("multu_post", MD_MULTU, 32'd6, 32'd7,
           32'd0, 32'd42, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
